// File: rtl/rs_encoder_serial.sv
// Symbol-serial systematic RS(7,5) encoder over GF(8), x^3+x+1.
// Message symbols pass through, then two LFSR parity symbols follow.
module rs_encoder_serial #(
  parameter int          SYMBOL_WIDTH = 3,
  parameter int          N            = 7,
  parameter int          K            = 5,
  parameter logic [2:0]  G1           = 3'b011,
  parameter logic [2:0]  G0           = 3'b110
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SYMBOL_WIDTH-1:0]     in_sym,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SYMBOL_WIDTH-1:0]     out_sym,
  output logic                        out_last,
  output logic                        cw_valid,
  output logic [N*SYMBOL_WIDTH-1:0]   cw_out
);

  typedef enum logic [1:0] {
    MSG  = 2'd0,
    PAR1 = 2'd1,
    PAR2 = 2'd2
  } state_t;

  // bit[2] holds the coefficient of 1, bit[0] that of alpha^2
  function automatic logic [2:0] mul_alpha(input logic [2:0] a);
    return {a[0], a[2] ^ a[0], a[1]};
  endfunction

  function automatic logic [2:0] gf_mul(input logic [2:0] a,
                                        input logic [2:0] b);
    logic [2:0] acc;
    logic [2:0] t;
    acc = '0;
    t   = a;
    for (int i = 0; i < 3; i++) begin
      if (b[2-i]) acc = acc ^ t;
      t = mul_alpha(t);
    end
    return acc;
  endfunction

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic [2:0] r1, r0;
  logic [2:0] fb;
  logic [K*SYMBOL_WIDTH-1:0] msg_sr;

  logic adv;
  logic ld_msg, ld_p1, ld_p2;
  logic last_msg;

  assign fb       = in_sym ^ r1;
  assign last_msg = (cnt == 3'(K - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= MSG;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MSG:  if (ld_msg && last_msg) state_nx = PAR1;
      PAR1: if (ld_p1) state_nx = PAR2;
      PAR2: if (ld_p2) state_nx = MSG;
      default: state_nx = MSG;
    endcase
  end

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = 1'b0;
    ld_msg   = 1'b0;
    ld_p1    = 1'b0;
    ld_p2    = 1'b0;
    unique case (state)
      MSG: begin
        in_ready = adv && !reset;
        ld_msg   = in_valid && adv;
      end
      PAR1:    ld_p1 = adv;
      PAR2:    ld_p2 = adv;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      r1        <= '0;
      r0        <= '0;
      msg_sr    <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_last  <= 1'b0;
      cw_valid  <= 1'b0;
      cw_out    <= '0;
    end else begin
      cw_valid <= ld_p2;
      if (ld_msg) begin
        r1        <= r0 ^ gf_mul(fb, G1);
        r0        <= gf_mul(fb, G0);
        msg_sr    <= {msg_sr[(K-1)*SYMBOL_WIDTH-1:0], in_sym};
        cnt       <= last_msg ? 3'd0 : cnt + 3'd1;
        out_sym   <= in_sym;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if (ld_p1) begin
        out_sym   <= r1;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if (ld_p2) begin
        out_sym   <= r0;
        out_valid <= 1'b1;
        out_last  <= 1'b1;
        cw_out    <= {msg_sr, r1, r0};
        r1        <= '0;
        r0        <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_encoder_serial.sv
// Scoreboard bench for rs_encoder_serial against a log/antilog GF(8)
// polynomial-division reference model.
module tb_rs_encoder_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sym = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_sym;
  logic        out_last;
  logic        cw_valid;
  logic [20:0] cw_out;

  int checks = 0;
  int failures = 0;
  int ncw_exp = 0;
  int ncw_seen = 0;
  bit rdy_mode = 1'b0;
  bit rdy_manual = 1'b1;

  logic [3:0]  sq[$];
  logic [20:0] cq[$];

  rs_encoder_serial dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_last(out_last),
    .cw_valid(cw_valid), .cw_out(cw_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = rdy_mode ? ($urandom_range(0, 9) < 7) : rdy_manual;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gexp(input int i);
    case (i % 7)
      0: return 3'b100;
      1: return 3'b010;
      2: return 3'b001;
      3: return 3'b110;
      4: return 3'b011;
      5: return 3'b111;
      default: return 3'b101;
    endcase
  endfunction

  function automatic int glog(input logic [2:0] a);
    for (int i = 0; i < 7; i++)
      if (gexp(i) == a) return i;
    return 0;
  endfunction

  function automatic logic [2:0] gmul(input logic [2:0] a,
                                      input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return gexp(glog(a) + glog(b));
  endfunction

  // c(x) = m(x)x^2 + (m(x)x^2 mod g(x)), g built from its roots
  function automatic logic [20:0] ref_cw(input logic [2:0] m[5]);
    logic [2:0] d[7];
    logic [2:0] g1, g0, q;
    logic [20:0] cw;
    g1 = gexp(1) ^ gexp(2);
    g0 = gmul(gexp(1), gexp(2));
    for (int i = 0; i < 5; i++) d[i] = m[i];
    d[5] = 3'd0;
    d[6] = 3'd0;
    for (int i = 0; i < 5; i++) begin
      q = d[i];
      d[i+1] = d[i+1] ^ gmul(q, g1);
      d[i+2] = d[i+2] ^ gmul(q, g0);
    end
    for (int i = 0; i < 5; i++) cw[20-3*i -: 3] = m[i];
    cw[5:3] = d[5];
    cw[2:0] = d[6];
    return cw;
  endfunction

  function automatic logic [2:0] syndrome(input logic [20:0] cw,
                                          input int p);
    logic [2:0] s;
    logic [20:0] c;
    s = 3'd0;
    c = cw;
    for (int i = 0; i < 7; i++)
      s = gmul(s, gexp(p)) ^ c[20-3*i -: 3];
    return s;
  endfunction

  always @(negedge clk) begin
    logic [3:0]  e;
    logic [20:0] ec;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sq.size() == 0) begin
        chk("sym_unexpected", {28'd0, out_last, out_sym}, 32'hffff);
      end else begin
        e = sq.pop_front();
        chk("out_sym", {29'd0, out_sym}, {29'd0, e[2:0]});
        chk("out_last", {31'd0, out_last}, {31'd0, e[3]});
      end
    end
    if (cw_valid === 1'b1) begin
      ncw_seen++;
      chk("cw_last_align", {31'd0, out_last}, 32'd1);
      chk("syn_alpha1", {29'd0, syndrome(cw_out, 1)}, 32'd0);
      chk("syn_alpha2", {29'd0, syndrome(cw_out, 2)}, 32'd0);
      if (cq.size() == 0) begin
        chk("cw_unexpected", {11'd0, cw_out}, 32'hffffffff);
      end else begin
        ec = cq.pop_front();
        chk("cw_out", {11'd0, cw_out}, {11'd0, ec});
      end
    end
  end

  task automatic send_cw(input logic [2:0] m[5], input int n,
                         input bit gaps, input bit hold);
    logic [20:0] cw;
    int t;
    cw = ref_cw(m);
    for (int i = 0; i < ((n == 5) ? 7 : n); i++)
      sq.push_back({(i == 6), cw[20-3*i -: 3]});
    if (n == 5) begin
      cq.push_back(cw);
      ncw_exp++;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_sym = m[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) begin
          @(posedge clk);
          #1;
          break;
        end
        @(posedge clk);
        #1;
        t++;
        if (t > 200) begin
          chk("accept_timeout", t, 0);
          break;
        end
      end
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sq.size() != 0 || cq.size() != 0) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", sq.size() + cq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] v1[5];
    logic [2:0] vg[5];
    logic [2:0] vz[5];
    logic [2:0] vr[5];
    int lowc;
    v1 = '{3'b000, 3'b001, 3'b110, 3'b011, 3'b001};
    vg = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
    vz = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_cw_valid", {31'd0, cw_valid}, 0);
    chk("rst_out_sym", {29'd0, out_sym}, 0);
    chk("rst_cw_out", {11'd0, cw_out}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    send_cw(v1, 5, 1'b0, 1'b0);
    lowc = 0;
    @(negedge clk);
    while (!in_ready && lowc < 20) begin
      lowc++;
      @(negedge clk);
    end
    chk("in_ready_low_cycles", lowc, 2);
    @(posedge clk);
    #1;
    drain();
    chk("cw_vec1_literal", {11'd0, cw_out},
        {11'd0, 21'b000_001_110_011_001_000_111});

    send_cw(vg, 5, 1'b0, 1'b0);
    drain();
    chk("cw_gx_literal", {11'd0, cw_out},
        {11'd0, 21'b000_000_000_000_100_011_110});
    send_cw(vz, 5, 1'b0, 1'b0);
    drain();

    send_cw(v1, 5, 1'b0, 1'b1);
    send_cw(vg, 5, 1'b0, 1'b0);
    drain();

    send_cw(v1, 5, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rdy_manual = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_out_sym", {29'd0, out_sym}, 0);
      chk("hold_out_valid", {31'd0, out_valid}, 1);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk);
      #1;
    end
    rdy_manual = 1'b1;
    drain();

    send_cw(v1, 3, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_out_last", {31'd0, out_last}, 0);
    chk("mid_rst_out_sym", {29'd0, out_sym}, 0);
    chk("mid_rst_cw_out", {11'd0, cw_out}, 0);
    chk("mid_rst_queue", sq.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready_after", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    send_cw(v1, 5, 1'b0, 1'b0);
    drain();

    rdy_mode = 1'b1;
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 5; i++) vr[i] = 3'($urandom_range(0, 7));
      send_cw(vr, 5, 1'b1, ($urandom_range(0, 1) == 1));
    end
    in_valid = 1'b0;
    drain();
    rdy_mode = 1'b0;

    chk("cw_count", ncw_seen, ncw_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_encoder_serial.md
Name: rs_encoder_serial

Overview:
- Symbol-serial, systematic RS(7,5) encoder over GF(8). It is the transmit-side counterpart of RS_Decoder.
- Accepts 5 message symbols on a valid/ready input, passes them through unchanged, then appends 2 parity symbols computed by a GF(8) LFSR.
- Also presents the full 21-bit codeword in parallel, in the same packing RS_Decoder consumes on its codeword port.

Parameters:
- SYMBOL_WIDTH, 3: bits per symbol. Only 3 is supported.
- N, 7: codeword length in symbols. Only 7 is supported.
- K, 5: message length in symbols. Only 5 is supported.
- G1, 3'b011: generator coefficient of x^1, equal to alpha^4.
- G0, 3'b110: generator coefficient of x^0, equal to alpha^3.

Ports:
- clk  in  1  clock. All logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_sym is valid.
- in_ready  out  1  block accepts in_sym this cycle.
- in_sym  in  SYMBOL_WIDTH  message symbol. Highest-degree symbol comes first.
- out_valid  out  1  out_sym is valid.
- out_ready  in  1  sink accepts out_sym this cycle.
- out_sym  out  SYMBOL_WIDTH  codeword symbol.
- out_last  out  1  marks the 7th symbol of a codeword.
- cw_valid  out  1  one-cycle pulse; cw_out holds a complete codeword.
- cw_out  out  N*SYMBOL_WIDTH  packed codeword. First symbol is at [20:18], last at [2:0].

Behaviour:
- Field arithmetic:
  - Primitive polynomial is x^3+x+1.
  - Symbol bit[2] is the coefficient of 1, bit[1] of alpha, bit[0] of alpha^2.
  - Elements: alpha^0=100, alpha^1=010, alpha^2=001, alpha^3=110, alpha^4=011, alpha^5=111, alpha^6=101.
  - Addition is XOR. Multiplication is combinational, by constant G1/G0 only.
- Generator: g(x)=(x+alpha)(x+alpha^2)=x^2+G1*x+G0.
- LFSR registers r1 and r0, both reset to 0. On each accepted message symbol u:
  - fb = u ^ r1
  - r1 <= r0 ^ (fb*G1)
  - r0 <= fb*G0
- FSM states: MSG, PAR1, PAR2. Reset state is MSG with cnt=0.
- Output advance condition: adv = !out_valid || out_ready. The output stage is a single register with no skid buffer.
- MSG:
  - in_ready = adv.
  - On in_valid && in_ready: out_sym <= in_sym, out_valid <= 1, LFSR updates, cw shift register captures the symbol, cnt++.
  - On the 5th accept (cnt==4): go to PAR1, cnt <= 0.
- PAR1:
  - in_ready = 0.
  - On adv: out_sym <= r1, out_valid <= 1, go to PAR2.
- PAR2:
  - in_ready = 0.
  - On adv: out_sym <= r0, out_valid <= 1, out_last <= 1, cw_valid <= 1.
  - cw_out <= {the 5 message symbols, r1, r0}.
  - Clear r1 and r0. Go to MSG.
- Output hold and clear:
  - If out_valid && !out_ready, out_sym and out_last hold stable and no state advances.
  - out_valid clears on out_ready when nothing new is loaded.
  - out_last clears when the next symbol loads or when out_valid clears.
- Latency and throughput:
  - Each symbol appears on out_sym 1 cycle after it is accepted.
  - Sustained throughput is 7 cycles per 5 message symbols.
  - cw_valid pulses exactly 1 cycle, in the cycle out_last first asserts.
  - cw_out holds its value until the next codeword completes.
- in_valid low in MSG: the LFSR and cnt hold. Gaps between message symbols are allowed.
- Simultaneous events: out_ready with a new accept in the same cycle replaces the output with no bubble.
- Reset, including mid-codeword:
  - Next edge: out_valid=0, out_last=0, cw_valid=0, in_ready=0 during reset, out_sym=0, cw_out=0, r1=r0=0, cnt=0, state MSG.
  - A partial codeword is discarded.
  - in_ready is 1 in the first cycle after reset deasserts.

Test Plan:
- Message 000,001,110,011,001 with out_ready=1 continuously -> out_sym sequence 000,001,110,011,001,000,111. cw_out=21'b000_001_110_011_001_000_111. in_ready low for 2 cycles.
- Message 000,000,000,000,100 -> parity 011,110, i.e. the codeword equals g(x). All-zero message -> all-zero codeword with cw_valid pulsing once.
- Back-to-back codewords (first vector, then the g(x) vector), in_valid held high -> LFSR clears between them; second parity is 011,110. No lost or duplicated symbols.
- out_ready low for 3 cycles while the PAR1 symbol is valid -> out_sym holds 000 and in_ready stays 0. On release, 111 follows with out_last=1.
- Reset asserted after 3 message symbols, then the first vector is re-sent -> outputs clear on the next edge, and the resent codeword is correct (parity 000,111).
- Random gaps on in_valid and random out_ready, 100 codewords checked against a GF(8) reference model -> every codeword has zero syndromes at alpha and alpha^2.
